// File: rtl/vga_sync_rx.sv
// Receive side of a VGA timing interface: recovers active-pixel coordinates from hs/vs/d_ena,
// measures line and frame periods and reports lock while that timing stays stable.
module vga_sync_rx #(
    parameter int   CW     = 10,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0,
    parameter int   H_TO   = 1000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          hs_i,
    input  logic          vs_i,
    input  logic          d_ena_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          pix_valid_o,
    output logic          sof_o,
    output logic          locked_o,
    output logic [CW-1:0] h_total_o,
    output logic [CW-1:0] v_total_o,
    output logic          err_o
);
    typedef enum logic [1:0] {IDLE, SYNC, MEAS, LOCKED} state_e;

    localparam logic [CW-1:0] MAX_CNT = '1;
    localparam logic [CW-1:0] TO_CNT  = CW'(H_TO);

    state_e        r_state;
    state_e        w_next;
    logic          r_hsA, r_hsB, r_vsA, r_vsB, r_deA, r_deB;
    logic [CW-1:0] r_hc, r_lc, r_xc, r_yc;
    logic          w_hsEdge, w_vsEdge, w_deFall;
    logic [CW-1:0] w_linePer;
    logic          w_lockErr;
    logic [CW-1:0] w_hTot, w_vTot;
    logic          w_locked, w_pixValid, w_sof, w_err;

    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == MAX_CNT) ? v : v + CW'(1);
    endfunction

    // Sync inputs idle at their inactive level so reset never fakes a sync edge on its own.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_hsA <= ~HS_POL;
            r_hsB <= ~HS_POL;
            r_vsA <= ~VS_POL;
            r_vsB <= ~VS_POL;
            r_deA <= 1'b0;
            r_deB <= 1'b0;
        end else begin
            r_hsA <= hs_i;
            r_hsB <= r_hsA;
            r_vsA <= vs_i;
            r_vsB <= r_vsA;
            r_deA <= d_ena_i;
            r_deB <= r_deA;
        end
    end

    assign w_hsEdge  = (r_hsA == HS_POL) && (r_hsB != HS_POL);
    assign w_vsEdge  = (r_vsA == VS_POL) && (r_vsB != VS_POL);
    assign w_deFall  = r_deB && !r_deA;
    assign w_linePer = satInc(r_hc);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_hc <= '0;
            r_lc <= '0;
            r_xc <= '0;
            r_yc <= '0;
        end else begin
            r_hc <= w_hsEdge ? '0 : satInc(r_hc);
            // A line whose hs edge coincides with the vs edge is line 0 of the new frame.
            if (w_vsEdge)      r_lc <= '0;
            else if (w_hsEdge) r_lc <= satInc(r_lc);
            if (w_hsEdge)      r_xc <= '0;
            else if (r_deA)    r_xc <= satInc(r_xc);
            if (w_vsEdge)      r_yc <= '0;
            else if (w_deFall) r_yc <= satInc(r_yc);
        end
    end

    assign w_lockErr = (w_hsEdge && (w_linePer != h_total_o)) ||
                       (w_vsEdge && (r_lc != v_total_o)) ||
                       (r_hc >= TO_CNT);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = SYNC;
            SYNC:    if (w_vsEdge)  w_next = MEAS;
            MEAS:    if (w_vsEdge)  w_next = LOCKED;
            LOCKED:  if (w_lockErr) w_next = SYNC;
            default: w_next = IDLE;
        endcase
    end

    // Lock-qualified outputs look at the next state so pixels never outlive locked_o.
    always_comb begin
        w_hTot     = h_total_o;
        w_vTot     = v_total_o;
        if (r_state == MEAS && w_hsEdge) w_hTot = w_linePer;
        if (r_state == MEAS && w_vsEdge) w_vTot = r_lc;
        w_locked   = (w_next == LOCKED);
        w_pixValid = w_locked && r_deA;
        w_sof      = w_pixValid && (r_xc == '0) && (r_yc == '0);
        w_err      = (r_state == LOCKED) && w_lockErr;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x_o         <= '0;
            y_o         <= '0;
            pix_valid_o <= 1'b0;
            sof_o       <= 1'b0;
            locked_o    <= 1'b0;
            h_total_o   <= '0;
            v_total_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            x_o         <= r_xc;
            y_o         <= r_yc;
            pix_valid_o <= w_pixValid;
            sof_o       <= w_sof;
            locked_o    <= w_locked;
            h_total_o   <= w_hTot;
            v_total_o   <= w_vTot;
            err_o       <= w_err;
        end
    end
endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx: 640x480 line timing (800 clk/line) with a shortened 6-line frame,
// driven into an active-low instance and an active-high instance of the receiver.
`timescale 1ns/1ps
module tb_vga_sync_rx;
    localparam int CW   = 10;
    localparam int HTOT = 800;
    localparam int HS_W = 96;
    localparam int HA_S = 144;
    localparam int HA_E = 784;
    localparam int VTOT = 6;
    localparam int VACT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic hs, vs, de;
    logic hsP, vsP;
    assign hsP = ~hs;
    assign vsP = ~vs;

    logic [CW-1:0] xN, yN, htN, vtN, xP, yP, htP, vtP;
    logic          pvN, sofN, lkN, errN, pvP, sofP, lkP, errP;

    vga_sync_rx #(.CW(CW), .HS_POL(1'b0), .VS_POL(1'b0), .H_TO(1000)) dutN (
        .clk_i(clk), .rst_ni(rst_n), .hs_i(hs), .vs_i(vs), .d_ena_i(de),
        .x_o(xN), .y_o(yN), .pix_valid_o(pvN), .sof_o(sofN), .locked_o(lkN),
        .h_total_o(htN), .v_total_o(vtN), .err_o(errN));

    vga_sync_rx #(.CW(CW), .HS_POL(1'b1), .VS_POL(1'b1), .H_TO(1000)) dutP (
        .clk_i(clk), .rst_ni(rst_n), .hs_i(hsP), .vs_i(vsP), .d_ena_i(de),
        .x_o(xP), .y_o(yP), .pix_valid_o(pvP), .sof_o(sofP), .locked_o(lkP),
        .h_total_o(htP), .v_total_o(vtP), .err_o(errP));

    int checks = 0;
    int passed = 0;
    int hpos = 0, vpos = 0, stretchRow = -1;
    bit hsKill = 0, sbOn = 0, runOk = 1;
    int expY[$];
    int runLen = 0, linesSeen = 0, sofCount = 0;
    logic [CW-1:0] runY = '0;

    task automatic drivePins();
        bit hsAct, vsAct;
        hsAct = (hpos < HS_W) && !hsKill;
        vsAct = (vpos == 3 && hpos >= 400) || (vpos == 4) || (vpos == 5 && hpos < 400);
        de    = (vpos < VACT) && (hpos >= HA_S) && (hpos < HA_E);
        hs    = ~hsAct;
        vs    = ~vsAct;
        if (sbOn && de && hpos == HA_S) expY.push_back(vpos);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        hpos++;
        if (hpos >= ((vpos == stretchRow) ? HTOT + 1 : HTOT)) begin
            if (vpos == stretchRow) stretchRow = -1;
            hpos = 0;
            vpos = (vpos == VTOT - 1) ? 0 : vpos + 1;
        end
        drivePins();
    endtask

    task automatic stepTo(input int v, input int h);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(vpos == v && hpos == h) && n < 2 * VTOT * (HTOT + 1));
        if (!(vpos == v && hpos == h)) begin
            checks++;
            $display("[TB] FAIL stepTo: raster at (%0d,%0d), want (%0d,%0d)", vpos, hpos, v, h);
        end
    endtask

    // Line-level scoreboard: each active line popped must match the row pushed by the driver.
    always @(negedge clk) begin
        if (sbOn) begin
            if (sofN) sofCount++;
            if (pvN) begin
                if (runLen == 0) runY = yN;
                if (xN !== CW'(runLen) || yN !== runY) runOk = 0;
                runLen++;
            end else if (runLen > 0) begin
                checks++;
                if (expY.size() == 0) begin
                    $display("[TB] FAIL line_unexpected: got y=%0d len=%0d, want no line", runY, runLen);
                end else begin
                    int ey;
                    ey = expY.pop_front();
                    if (runOk && runY === CW'(ey) && runLen == HA_E - HA_S) passed++;
                    else $display("[TB] FAIL line: got y=%0d len=%0d xseq_ok=%0d, want y=%0d len=%0d xseq_ok=1",
                                  runY, runLen, runOk, ey, HA_E - HA_S);
                end
                linesSeen++;
                runLen = 0;
                runOk  = 1;
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        drivePins();
        repeat (3) tick();
        @(negedge clk);
        checks++; if (lkN !== 1'b0)  $display("[TB] FAIL rst_locked: got %b want 0", lkN); else passed++;
        checks++; if (pvN !== 1'b0)  $display("[TB] FAIL rst_pix_valid: got %b want 0", pvN); else passed++;
        checks++; if (sofN !== 1'b0) $display("[TB] FAIL rst_sof: got %b want 0", sofN); else passed++;
        checks++; if (errN !== 1'b0) $display("[TB] FAIL rst_err: got %b want 0", errN); else passed++;
        checks++; if (xN !== '0)     $display("[TB] FAIL rst_x: got %0d want 0", xN); else passed++;
        checks++; if (yN !== '0)     $display("[TB] FAIL rst_y: got %0d want 0", yN); else passed++;
        checks++; if (htN !== '0)    $display("[TB] FAIL rst_h_total: got %0d want 0", htN); else passed++;
        checks++; if (vtN !== '0)    $display("[TB] FAIL rst_v_total: got %0d want 0", vtN); else passed++;
        checks++;
        if ({xP, yP, htP, vtP, pvP, sofP, lkP, errP} !== '0)
            $display("[TB] FAIL rst_pos_dut: got %h want 0", {xP, yP, htP, vtP, pvP, sofP, lkP, errP});
        else passed++;
        stepTo(0, 10);
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        stepTo(3, 400);
        tick(); tick();
        @(negedge clk);
        checks++; if (lkN !== 1'b0) $display("[TB] FAIL lock_first_vs: got %b want 0", lkN); else passed++;
        checks++; if (htN !== '0)   $display("[TB] FAIL h_total_unmeasured: got %0d want 0", htN); else passed++;
        stepTo(3, 400);
        tick();
        @(negedge clk);
        checks++; if (lkN !== 1'b0) $display("[TB] FAIL lock_early: got %b want 0", lkN); else passed++;
        tick();
        @(negedge clk);
        checks++; if (lkN !== 1'b1)    $display("[TB] FAIL lock_second_vs: got %b want 1", lkN); else passed++;
        checks++; if (htN !== CW'(800)) $display("[TB] FAIL h_total: got %0d want 800", htN); else passed++;
        checks++; if (vtN !== CW'(VTOT)) $display("[TB] FAIL v_total: got %0d want %0d", vtN, VTOT); else passed++;
        checks++; if (lkP !== 1'b1)    $display("[TB] FAIL pos_locked: got %b want 1", lkP); else passed++;
        checks++; if (htP !== CW'(800)) $display("[TB] FAIL pos_h_total: got %0d want 800", htP); else passed++;
        checks++; if (vtP !== CW'(VTOT)) $display("[TB] FAIL pos_v_total: got %0d want %0d", vtP, VTOT); else passed++;
    endtask

    task automatic test_frame();
        expY.delete();
        linesSeen = 0;
        sofCount  = 0;
        sbOn      = 1;
        stepTo(0, HA_S);
        tick();
        @(negedge clk);
        checks++; if (sofN !== 1'b0 || pvN !== 1'b0)
            $display("[TB] FAIL sof_early: got sof=%b pv=%b want 0 0", sofN, pvN); else passed++;
        tick();
        @(negedge clk);
        checks++; if (sofN !== 1'b1) $display("[TB] FAIL sof_latency: got %b want 1", sofN); else passed++;
        checks++; if (pvN !== 1'b1 || xN !== '0 || yN !== '0)
            $display("[TB] FAIL first_pixel: got pv=%b x=%0d y=%0d want 1 0 0", pvN, xN, yN); else passed++;
        stepTo(3, 0);
        checks++; if (linesSeen != VACT) $display("[TB] FAIL lines_seen: got %0d want %0d", linesSeen, VACT); else passed++;
        checks++; if (expY.size() != 0)  $display("[TB] FAIL lines_pending: got %0d want 0", expY.size()); else passed++;
        checks++; if (sofCount != 1)     $display("[TB] FAIL sof_count: got %0d want 1", sofCount); else passed++;
        sbOn = 0;
    endtask

    task automatic waitRelock(input string tag);
        stepTo(3, 400);
        tick(); tick();
        @(negedge clk);
        checks++; if (lkN !== 1'b0) $display("[TB] FAIL %s_relock_one_vs: got %b want 0", tag, lkN); else passed++;
        stepTo(3, 400);
        tick();
        @(negedge clk);
        checks++; if (lkN !== 1'b0) $display("[TB] FAIL %s_relock_early: got %b want 0", tag, lkN); else passed++;
        tick();
        @(negedge clk);
        checks++; if (lkN !== 1'b1) $display("[TB] FAIL %s_relock: got %b want 1", tag, lkN); else passed++;
    endtask

    task automatic test_stretch();
        @(negedge clk);
        checks++; if (lkN !== 1'b1) $display("[TB] FAIL stretch_pre_locked: got %b want 1", lkN); else passed++;
        stretchRow = 1;
        stepTo(2, 0);
        tick();
        @(negedge clk);
        checks++; if (errN !== 1'b0 || lkN !== 1'b1)
            $display("[TB] FAIL stretch_early: got err=%b lock=%b want 0 1", errN, lkN); else passed++;
        tick();
        @(negedge clk);
        checks++; if (errN !== 1'b1) $display("[TB] FAIL stretch_err: got %b want 1", errN); else passed++;
        checks++; if (lkN !== 1'b0)  $display("[TB] FAIL stretch_unlock: got %b want 0", lkN); else passed++;
        tick();
        @(negedge clk);
        checks++; if (errN !== 1'b0) $display("[TB] FAIL stretch_err_pulse: got %b want 0", errN); else passed++;
        checks++; if (htN !== CW'(800)) $display("[TB] FAIL stretch_h_hold: got %0d want 800", htN); else passed++;
        waitRelock("stretch");
    endtask

    task automatic test_timeout();
        stepTo(1, 0);
        for (int n = 1; n <= 1200; n++) begin
            if (n == 100) hsKill = 1;
            tick();
            if (n == 1002) begin
                @(negedge clk);
                checks++; if (errN !== 1'b0 || lkN !== 1'b1)
                    $display("[TB] FAIL timeout_early: got err=%b lock=%b want 0 1", errN, lkN); else passed++;
            end else if (n == 1003) begin
                @(negedge clk);
                checks++; if (errN !== 1'b1) $display("[TB] FAIL timeout_err: got %b want 1", errN); else passed++;
                checks++; if (lkN !== 1'b0)  $display("[TB] FAIL timeout_unlock: got %b want 0", lkN); else passed++;
            end else if (n == 1004) begin
                @(negedge clk);
                checks++; if (errN !== 1'b0) $display("[TB] FAIL timeout_err_pulse: got %b want 0", errN); else passed++;
            end
        end
        hsKill = 0;
        waitRelock("timeout");
    endtask

    task automatic test_reset_mid();
        stepTo(1, 300);
        @(negedge clk);
        checks++; if (lkN !== 1'b1 || pvN !== 1'b1)
            $display("[TB] FAIL midrst_pre: got lock=%b pv=%b want 1 1", lkN, pvN); else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (lkN !== 1'b0) $display("[TB] FAIL midrst_locked: got %b want 0", lkN); else passed++;
        checks++; if (pvN !== 1'b0) $display("[TB] FAIL midrst_pix_valid: got %b want 0", pvN); else passed++;
        checks++; if (xN !== '0 || yN !== '0)
            $display("[TB] FAIL midrst_xy: got x=%0d y=%0d want 0 0", xN, yN); else passed++;
        checks++; if (htN !== '0 || vtN !== '0)
            $display("[TB] FAIL midrst_totals: got h=%0d v=%0d want 0 0", htN, vtN); else passed++;
        checks++; if (sofN !== 1'b0 || errN !== 1'b0)
            $display("[TB] FAIL midrst_pulses: got sof=%b err=%b want 0 0", sofN, errN); else passed++;
        waitRelock("midrst");
        checks++; if (htN !== CW'(800) || vtN !== CW'(VTOT))
            $display("[TB] FAIL midrst_totals_relock: got h=%0d v=%0d want 800 %0d", htN, vtN, VTOT); else passed++;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_lock();
        test_frame();
        test_stretch();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
